// File: rtl/fifo_drain_sched.sv
// Read-side scheduler for the 4-in/32-out flush FIFO: round-robin read grants and flush sequencing.
// Optional stranded-data auto-flush is built when FIFO_DRAIN_AUTOFLUSH_EN is defined.
module fifo_drain_sched #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [1:0]  flush_i,
  output logic [1:0]  gnt_o,
  output logic [31:0] data_o,
  output logic        data_vld_o,
  output logic        flush_word_o,
  output logic [1:0]  flush_done_o,
  output logic        fifo_rd_o,
  output logic        fifo_flush_o,
  input  logic [31:0] fifo_rd_data_i,
  input  logic        fifo_data_avail_i,
  input  logic        fifo_empty_i,
  input  logic        fifo_flush_done_i
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t r_state;
  logic   r_owner;
  logic   r_rr;

  logic [1:0] w_gnt;
  logic [1:0] w_fdone;
  logic       w_rd;
  logic       w_fflush;
  logic       w_fword;
  logic       w_start;
  logic       w_sel;
  logic       w_auto_hit;
  logic       w_auto;
  logic       w_req_win;
  logic       w_flush_win;

  assign w_req_win   = req_i[r_rr]   ? r_rr : ~r_rr;
  assign w_flush_win = flush_i[r_rr] ? r_rr : ~r_rr;

`ifdef FIFO_DRAIN_AUTOFLUSH_EN
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  logic [7:0] r_timer;
  logic       r_auto;

  assign w_auto_hit = (r_timer == TMAX);
  assign w_auto     = r_auto;

  // Counts idle cycles with only a partial word stored; held at TMAX until serviced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
      r_auto  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && !w_start && !fifo_empty_i && !fifo_data_avail_i) begin
        if (r_timer != TMAX) r_timer <= r_timer + 8'd1;
      end else begin
        r_timer <= '0;
      end
      if (w_start) r_auto <= ~|flush_i;
    end
  end
`else
  assign w_auto_hit = 1'b0;
  assign w_auto     = 1'b0;
`endif

  always_comb begin
    w_gnt    = '0;
    w_fdone  = '0;
    w_rd     = 1'b0;
    w_fflush = 1'b0;
    w_fword  = 1'b0;
    w_start  = 1'b0;
    w_sel    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|flush_i && fifo_empty_i) begin
          w_fdone = flush_i;
        end else if (|flush_i) begin
          w_start = 1'b1;
          w_sel   = w_flush_win;
        end else if (w_auto_hit && |req_i) begin
          w_start = 1'b1;
          w_sel   = w_req_win;
        end else if (fifo_data_avail_i && |req_i) begin
          w_rd  = 1'b1;
          w_sel = w_req_win;
          w_gnt = 2'b01 << w_sel;
        end
      end
      S_FLUSH: begin
        w_fflush = 1'b1;
        w_sel    = r_owner;
        if (fifo_flush_done_i) begin
          if (!w_auto) w_fdone = 2'b01 << r_owner;
        end else if (!fifo_empty_i) begin
          w_gnt   = 2'b01 << r_owner;
          w_fword = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state <= S_FLUSH;
          r_owner <= w_sel;
        end
        S_FLUSH: if (fifo_flush_done_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_start || |w_gnt) r_rr <= ~w_sel;
    end
  end

  // Outputs are forced low while reset is held so a mid-flush reset drops them at once.
  assign gnt_o        = rst ? 2'b00 : w_gnt;
  assign data_o       = rst ? 32'd0 : fifo_rd_data_i;
  assign data_vld_o   = |gnt_o;
  assign flush_word_o = rst ? 1'b0 : w_fword;
  assign flush_done_o = rst ? 2'b00 : w_fdone;
  assign fifo_rd_o    = rst ? 1'b0 : w_rd;
  assign fifo_flush_o = rst ? 1'b0 : w_fflush;

endmodule

// File: doc/fifo_drain_sched.md
# fifo_drain_sched

Read-side scheduler for the asymmetric 4-bit-in / 32-bit-out flush FIFO. Shares the FIFO's single read port between two consumers with round-robin grants, and sequences the FIFO's flush handshake on behalf of a requesting consumer. Optionally issues an automatic flush when partial data has been stranded too long. Sits directly on the FIFO read interface; consumers see a one-hot grant with the 32-bit word.

## Interface
- `TIMEOUT`, 16: IDLE cycles with partial-only data (non-empty, <32 bits) before an auto-flush; legal range 2..255.
- `clk`  in  1  clock; all flops posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_i`  in  2  consumer n wants one 32-bit word; level, sampled every cycle.
- `flush_i`  in  2  consumer n requests a flush; held high until its `flush_done_o` bit pulses.
- `gnt_o`  out  2  one-hot; the word on `data_o` this cycle belongs to consumer n.
- `data_o`  out  32  pass-through of `fifo_rd_data_i`.
- `data_vld_o`  out  1  `data_o` valid; equals `|gnt_o`.
- `flush_word_o`  out  1  current word was delivered under flush and may be zero-padded.
- `flush_done_o`  out  2  one-cycle pulse; consumer n's flush is complete.
- `fifo_rd_o`  out  1  FIFO read strobe.
- `fifo_flush_o`  out  1  FIFO flush request.
- `fifo_rd_data_i`  in  32  FIFO read data, valid in the strobe cycle.
- `fifo_data_avail_i`  in  1  FIFO holds ≥32 bits.
- `fifo_empty_i`  in  1  FIFO empty.
- `fifo_flush_done_i`  in  1  FIFO flush complete.

## Operation
- State machine: IDLE, FLUSH. Registered state: state, owner (1 bit), auto flag, RR pointer `rr` (1 bit), timer (8 bits).
- All outputs are combinational from registered state and current inputs. Consumers must accept every granted word; there is no backpressure.
- RR winner among a request vector: consumer `rr` if its bit is set, else the other. After any grant or flush start, `rr` is set to the other consumer (not the winner).
- IDLE, evaluated in priority order:
  1. Any `flush_i` high with `fifo_empty_i`=1: pulse `flush_done_o` for that bit (both bits if both high). Stay IDLE.
  2. Any `flush_i` high with the FIFO non-empty: no read this cycle. Next cycle enter FLUSH with owner = RR winner of `flush_i` and auto=0.
  3. Auto-flush: the timer reaches `TIMEOUT`-1 and `|req_i`. Enter FLUSH with owner = RR winner of `req_i` and auto=1.
  4. Otherwise, if `fifo_data_avail_i` and `|req_i`: `fifo_rd_o`=1 and `gnt_o` = RR winner.
- Timer: increments in IDLE while `!fifo_empty_i && !fifo_data_avail_i`; otherwise clears. It saturates at `TIMEOUT`-1 and clears on entry to FLUSH.
- FLUSH:
  - `fifo_flush_o`=1 every cycle.
  - When `!fifo_empty_i`: `gnt_o`=owner, `data_vld_o`=1, `flush_word_o`=1.
  - `req_i` is ignored; the non-owner's `flush_i` waits.
  - When `fifo_flush_done_i`=1: no grant that cycle. If auto=0, pulse `flush_done_o[owner]`. Return to IDLE next cycle.

## Timing
- Read latency is 0: grant, strobe and data all occur in the same cycle.
- Maximum read throughput is one word per cycle, alternating between consumers when both request.
- Flush start costs one bubble cycle: the request cycle. Flush words then stream one per cycle until `fifo_flush_done_i`.
- The `flush_done_o` pulse lasts exactly one cycle. The consumer must drop `flush_i` on the following cycle; a still-high `flush_i` in IDLE is treated as a new request.
- Reset values:
  - State IDLE, `rr`=0, timer=0, owner=0, auto=0.
  - Every output is 0.
- Reset asserted mid-FLUSH: `fifo_flush_o` drops asynchronously, no `flush_done_o` is issued, and consumers must re-request.

## Configuration
- `FIFO_DRAIN_AUTOFLUSH_EN` defined:
  - The timer and auto flag are built.
  - IDLE step 3 is active.
- `FIFO_DRAIN_AUTOFLUSH_EN` undefined:
  - The timer and auto flag are removed.
  - Flushes occur only from `flush_i`.
  - `TIMEOUT` is ignored.
  - Partial data waits indefinitely.

## Test plan
- Both `req_i`=2'b11, `fifo_data_avail_i` held 1 for 4 cycles: `gnt_o` sequence 01, 10, 01, 10; `fifo_rd_o`=1 each cycle; `data_o` = `fifo_rd_data_i`.
- `flush_i`=2'b10 with 12 bits stored in the FIFO:
  - Cycle 0: no grant.
  - Cycle 1: `fifo_flush_o`=1, `gnt_o`=10, `flush_word_o`=1, word carries 3 nibbles plus 0x0 padding.
  - Next cycle: the FIFO reports done, `flush_done_o`=10.
- `flush_i`=2'b01 while `fifo_empty_i`=1: `flush_done_o`=01 in the same cycle; `fifo_flush_o` never asserts.
- Both `flush_i` set with `rr`=1: consumer 1 flushes first, then consumer 0 gets its own FLUSH. Each receives one `flush_done_o` pulse.
- With `FIFO_DRAIN_AUTOFLUSH_EN`, `TIMEOUT`=4, 8 bits stored, `req_i`=2'b01:
  - After 3 IDLE cycles, enter FLUSH with auto=1.
  - The padded word is granted to consumer 0.
  - No `flush_done_o` pulse.
  - Without the macro, no flush ever occurs.
- Reset asserted during FLUSH: all outputs 0 immediately. After release, state is IDLE with `rr`=0.
